branch_resolve: RTL and testbench

- Back end of the fetch/BTB feedback loop.
- Records every predicted branch leaving decode in an in-order tracking queue and accepts out-of-order outcomes from execute.
- Retires entries in program order and drives fb_en/fb_PC/fb_taken/fb_predictedPC/fb_mispredict back to fetch.
- Asserts stall to fetch when the queue is full; flushes younger entries on a mispredict.

---
 rtl/branch_resolve.sv | 153 +++++++++++++++
 tb/tb_branch_resolve.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: back end of the fetch/BTB feedback loop.
//
// Every predicted branch leaving decode is pushed into an in-order tracking
// queue. Execute returns outcomes in any order, tagged with the queue slot.
// Entries retire in program order, one per cycle, and produce registered
// one-cycle feedback pulses for fetch/BTB. A mispredicting retire discards
// all younger entries and holds the queue in FLUSH for one cycle.
//
// Optional feature: define BRRES_STATS_EN to add saturating retire and
// mispredict counters (stat_branches, stat_mispredicts).
//
// Ports:
//   clk, reset         clock, synchronous active-low reset
//   alloc*             branch push from decode (pc, predicted dir/target)
//   alloc_tag          slot the pushed branch receives (current tail)
//   ex_valid/tag/...   resolved outcome from execute
//   stall              queue full or flushing; fetch/decode must hold
//   fb_*               registered retire feedback to fetch/BTB
//   stat_*             (BRRES_STATS_EN only) saturating event counters
module branch_resolve #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PCW   = 32,
  localparam int unsigned TW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           alloc,
  input  logic [PCW-1:0] alloc_pc,
  input  logic           alloc_taken,
  input  logic [PCW-1:0] alloc_target,
  output logic [TW-1:0]  alloc_tag,
  input  logic           ex_valid,
  input  logic [TW-1:0]  ex_tag,
  input  logic           ex_taken,
  input  logic [PCW-1:0] ex_target,
  output logic           stall,
  output logic           fb_en,
  output logic [PCW-1:0] fb_PC,
  output logic           fb_taken,
  output logic [PCW-1:0] fb_predictedPC,
  output logic           fb_mispredict
`ifdef BRRES_STATS_EN
  ,
  output logic [31:0]    stat_branches,
  output logic [31:0]    stat_mispredicts
`endif
);

  localparam logic [TW:0] FULL_CNT = (TW+1)'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e          state_q;
  logic [TW-1:0]   head_q, tail_q;
  logic [TW:0]     count_q;

  logic [DEPTH-1:0] valid_q, done_q, pred_taken_q, act_taken_q;
  logic [PCW-1:0]   pc_q          [DEPTH];
  logic [PCW-1:0]   pred_target_q [DEPTH];
  logic [PCW-1:0]   act_target_q  [DEPTH];

  logic            alloc_ok, res_ok, retire, head_mis;
  logic [PCW-1:0]  head_next_pc;

  // stall is based on pre-retire occupancy, so a full queue refuses an
  // alloc even in the cycle a retire frees a slot.
  assign stall     = (count_q == FULL_CNT) || (state_q == FLUSH);
  assign alloc_tag = tail_q;
  assign alloc_ok  = alloc && !stall;
  assign res_ok    = ex_valid && (state_q == RUN) && valid_q[ex_tag] && !done_q[ex_tag];
  // Uses the registered done bit, so a head resolved this cycle retires next cycle.
  assign retire    = (state_q == RUN) && valid_q[head_q] && done_q[head_q];

  assign head_mis = (pred_taken_q[head_q] != act_taken_q[head_q]) ||
                    (pred_taken_q[head_q] && act_taken_q[head_q] &&
                     (pred_target_q[head_q] != act_target_q[head_q]));
  assign head_next_pc = act_taken_q[head_q] ? act_target_q[head_q]
                                            : pc_q[head_q] + PCW'(4);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= RUN;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      fb_en          <= 1'b0;
      fb_PC          <= '0;
      fb_taken       <= 1'b0;
      fb_predictedPC <= '0;
      fb_mispredict  <= 1'b0;
    end else begin
      fb_en          <= retire;
      fb_PC          <= retire ? pc_q[head_q] : '0;
      fb_taken       <= retire && act_taken_q[head_q];
      fb_predictedPC <= retire ? head_next_pc : '0;
      fb_mispredict  <= retire && head_mis;

      case (state_q)
        RUN: begin
          if (res_ok) begin
            done_q[ex_tag]       <= 1'b1;
            act_taken_q[ex_tag]  <= ex_taken;
            act_target_q[ex_tag] <= ex_target;
          end
          if (alloc_ok) begin
            valid_q[tail_q]       <= 1'b1;
            done_q[tail_q]        <= 1'b0;
            pc_q[tail_q]          <= alloc_pc;
            pred_taken_q[tail_q]  <= alloc_taken;
            pred_target_q[tail_q] <= alloc_target;
            tail_q                <= tail_q + TW'(1);
          end
          if (retire) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + TW'(1);
          end
          count_q <= count_q + (TW+1)'(alloc_ok) - (TW+1)'(retire);

          // Flush overrides the per-entry updates above, including any
          // alloc accepted in the same cycle.
          if (retire && head_mis) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= head_q + TW'(1);
            tail_q  <= head_q + TW'(1);
            count_q <= '0;
            state_q <= FLUSH;
          end
        end
        FLUSH:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef BRRES_STATS_EN
  // Counters step on the same edge that raises fb_en / fb_mispredict.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (retire && (stat_branches != '1))
        stat_branches <= stat_branches + 32'd1;
      if (retire && head_mis && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve (DEPTH=8, PCW=32).
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alloc = 1'b0;
  logic [31:0] alloc_pc = '0;
  logic        alloc_taken = 1'b0;
  logic [31:0] alloc_target = '0;
  logic [2:0]  alloc_tag;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_tag = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        stall;
  logic        fb_en;
  logic [31:0] fb_PC;
  logic        fb_taken;
  logic [31:0] fb_predictedPC;
  logic        fb_mispredict;
`ifdef BRRES_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] npc;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  branch_resolve #(.DEPTH(8), .PCW(32)) dut (
    .clk(clk), .reset(reset),
    .alloc(alloc), .alloc_pc(alloc_pc), .alloc_taken(alloc_taken),
    .alloc_target(alloc_target), .alloc_tag(alloc_tag),
    .ex_valid(ex_valid), .ex_tag(ex_tag), .ex_taken(ex_taken), .ex_target(ex_target),
    .stall(stall), .fb_en(fb_en), .fb_PC(fb_PC), .fb_taken(fb_taken),
    .fb_predictedPC(fb_predictedPC), .fb_mispredict(fb_mispredict)
`ifdef BRRES_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // Reference model of one retire pulse.
  function automatic exp_t mk_exp(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                                  input logic at, input logic [31:0] atgt);
    exp_t e;
    e.pc    = pc;
    e.taken = at;
    e.npc   = at ? atgt : pc + 32'd4;
    e.mis   = (pt != at) || (pt && at && (ptgt != atgt));
    return e;
  endfunction

  // Scoreboard: every fb_en pulse must match the oldest expectation;
  // idle cycles must show all-zero feedback.
  always @(negedge clk) begin
    if (reset) begin
      n_total++;
      if (fb_en) begin
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_fb: got fb_en=1 fb_PC=%h, required no pulse", fb_PC);
        end else begin
          mon_e = exp_q.pop_front();
          if ({fb_PC, fb_taken, fb_predictedPC, fb_mispredict} !== {mon_e.pc, mon_e.taken, mon_e.npc, mon_e.mis})
            $display("FAIL fb_pulse: got pc=%h taken=%b npc=%h mis=%b, required pc=%h taken=%b npc=%h mis=%b",
                     fb_PC, fb_taken, fb_predictedPC, fb_mispredict,
                     mon_e.pc, mon_e.taken, mon_e.npc, mon_e.mis);
          else
            n_pass++;
        end
      end else begin
        if ({fb_PC, fb_taken, fb_predictedPC, fb_mispredict} !== 66'd0)
          $display("FAIL fb_idle_zero: got pc=%h taken=%b npc=%h mis=%b, required all 0",
                   fb_PC, fb_taken, fb_predictedPC, fb_mispredict);
        else
          n_pass++;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    alloc = 1'b0;
    ex_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                          output logic [2:0] tag);
    alloc = 1'b1;
    alloc_pc = pc;
    alloc_taken = t;
    alloc_target = tgt;
    #0 tag = alloc_tag;
    @(posedge clk);
    #1 alloc = 1'b0;
  endtask

  task automatic do_resolve(input logic [2:0] tag, input logic t, input logic [31:0] tgt);
    ex_valid = 1'b1;
    ex_tag = tag;
    ex_taken = t;
    ex_target = tgt;
    @(posedge clk);
    #1 ex_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    repeat (4) @(negedge clk);
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL drain: got %0d pending pulses, required 0", exp_q.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_total++;
    if ({stall, fb_en, fb_mispredict, alloc_tag} !== 6'd0)
      $display("FAIL reset_state: got stall=%b fb_en=%b mis=%b tag=%0d, required all 0",
               stall, fb_en, fb_mispredict, alloc_tag);
    else
      n_pass++;
  endtask

  task automatic test_correct();
    logic [2:0] tag;
    do_reset();
    do_alloc(32'h100, 1'b1, 32'h200, tag);
    n_total++;
    if (tag !== 3'd0) $display("FAIL correct_tag: got %0d, required 0", tag);
    else n_pass++;
    exp_q.push_back(mk_exp(32'h100, 1'b1, 32'h200, 1'b1, 32'h200));
    do_resolve(3'd0, 1'b1, 32'h200);
    @(negedge clk);
    n_total++;
    if (fb_en !== 1'b0) $display("FAIL retire_early: got fb_en=%b, required 0", fb_en);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (fb_en !== 1'b1) $display("FAIL retire_latency: got fb_en=%b, required 1", fb_en);
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_mispredict();
    logic [2:0] tag;
    bit seen = 1'b0;
    do_reset();
    do_alloc(32'h40, 1'b1, 32'h80, tag);
    exp_q.push_back(mk_exp(32'h40, 1'b1, 32'h80, 1'b0, 32'h0));
    do_alloc(32'h50, 1'b0, 32'h0, tag);
    n_total++;
    if (tag !== 3'd1) $display("FAIL mis_tag1: got %0d, required 1", tag);
    else n_pass++;
    do_resolve(3'd0, 1'b0, 32'h0);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (fb_en) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL mis_pulse_timeout: got no fb_en, required one");
    else n_pass++;
    n_total++;
    if ({stall, fb_mispredict} !== 2'b11)
      $display("FAIL flush_stall: got stall=%b mis=%b, required 1 1", stall, fb_mispredict);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({stall, alloc_tag} !== {1'b0, 3'd1})
      $display("FAIL flush_end: got stall=%b tag=%0d, required 0 1", stall, alloc_tag);
    else n_pass++;
    do_resolve(3'd1, 1'b0, 32'h0);
    wait_drain();
  endtask

  task automatic test_out_of_order();
    logic [2:0] tag;
    logic [31:0] pcs [3];
    logic        tk  [3];
    logic [31:0] tg  [3];
    pcs = '{32'h1000, 32'h1004, 32'h1008};
    tk  = '{1'b1, 1'b0, 1'b1};
    tg  = '{32'h2000, 32'h0, 32'h3000};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_alloc(pcs[i], tk[i], tg[i], tag);
      exp_q.push_back(mk_exp(pcs[i], tk[i], tg[i], tk[i], tg[i]));
      n_total++;
      if (tag !== 3'(i)) $display("FAIL ooo_tag: got %0d, required %0d", tag, i);
      else n_pass++;
    end
    do_resolve(3'd2, tk[2], tg[2]);
    do_resolve(3'd2, 1'b0, 32'hDEAD);  // already done: must be ignored
    do_resolve(3'd0, tk[0], tg[0]);
    do_resolve(3'd1, tk[1], tg[1]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (fb_en !== 1'b1) $display("FAIL ooo_back_to_back: got fb_en=%b in pulse %0d, required 1", fb_en, i);
      else n_pass++;
    end
    wait_drain();
  endtask

  task automatic test_full();
    logic [2:0] tag;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_alloc(32'h800 + 32'(i * 4), 1'b0, 32'h0, tag);
      n_total++;
      if (tag !== 3'(i)) $display("FAIL full_tag: got %0d, required %0d", tag, i);
      else n_pass++;
    end
    n_total++;
    if (stall !== 1'b1) $display("FAIL full_stall: got %b, required 1", stall);
    else n_pass++;
    do_alloc(32'h900, 1'b0, 32'h0, tag);
    n_total++;
    if ({stall, alloc_tag} !== {1'b1, 3'd0})
      $display("FAIL full_drop: got stall=%b tag=%0d, required 1 0", stall, alloc_tag);
    else n_pass++;
    exp_q.push_back(mk_exp(32'h800, 1'b0, 32'h0, 1'b0, 32'h0));
    do_resolve(3'd0, 1'b0, 32'h0);
    n_total++;
    if (stall !== 1'b1) $display("FAIL full_retire_cycle_stall: got %b, required 1", stall);
    else n_pass++;
    do_alloc(32'hA00, 1'b0, 32'h0, tag);  // same cycle as retire: refused
    n_total++;
    if ({stall, alloc_tag} !== {1'b0, 3'd0})
      $display("FAIL full_alloc_retire: got stall=%b tag=%0d, required 0 0", stall, alloc_tag);
    else n_pass++;
    do_alloc(32'hB00, 1'b0, 32'h0, tag);
    n_total++;
    if ({tag, stall, alloc_tag} !== {3'd0, 1'b1, 3'd1})
      $display("FAIL full_refill: got tag=%0d stall=%b next=%0d, required 0 1 1", tag, stall, alloc_tag);
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_target_wrap();
    logic [2:0] tag;
    do_reset();
    do_alloc(32'hFFFF_FFFC, 1'b1, 32'h300, tag);
    exp_q.push_back(mk_exp(32'hFFFF_FFFC, 1'b1, 32'h300, 1'b1, 32'h304));
    do_resolve(3'd0, 1'b1, 32'h304);
    wait_drain();
    do_alloc(32'hFFFF_FFFC, 1'b1, 32'h300, tag);
    n_total++;
    if (tag !== 3'd1) $display("FAIL wrap_tag: got %0d, required 1", tag);
    else n_pass++;
    exp_q.push_back(mk_exp(32'hFFFF_FFFC, 1'b1, 32'h300, 1'b0, 32'h0));
    do_resolve(3'd1, 1'b0, 32'h0);
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    logic [2:0] tag;
    do_reset();
    for (int i = 0; i < 3; i++) do_alloc(32'h500 + 32'(i * 4), 1'b0, 32'h0, tag);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) do_resolve(3'(i), 1'b0, 32'h0);
    repeat (6) @(negedge clk);
    n_total++;
    if ({stall, alloc_tag, fb_en} !== 5'd0)
      $display("FAIL midflight_reset: got stall=%b tag=%0d fb_en=%b, required 0 0 0", stall, alloc_tag, fb_en);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict();
    test_out_of_order();
    test_full();
    test_target_wrap();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required completion");
    $fatal(1);
  end

endmodule
